// File: rtl/t05_huffman_decoder.sv
// Huffman bitstream decoder: walks the node-SRAM tree one bit per handshake
// and emits one character per leaf reached, using a cached root to avoid re-reads.
module t05_huffman_decoder #(
    parameter logic [3:0]  DECODE_STATE = 4'd8,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       en_state,
    input  logic [6:0]       root_index,
    input  logic [CNT_W-1:0] total_chars,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    output logic             mem_rd,
    output logic [6:0]       mem_addr,
    input  logic [63:0]      mem_rdata,
    input  logic             mem_ack,
    output logic [7:0]       char_out,
    output logic             char_valid,
    output logic [CNT_W-1:0] char_count,
    output logic [CNT_W-1:0] bit_count,
    output logic             err,
    output logic             fin_state
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_BIT,
        S_EMIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t           state, state_n;
    logic             enabled;
    logic [8:0]       cur_left, cur_right;
    logic [8:0]       root_left, root_right;
    logic [8:0]       child;
    logic             root_flag;
    logic [CNT_W-1:0] total_q;
    logic             unused_rdata;

    assign enabled      = (en_state == DECODE_STATE);
    assign bit_ready    = (state == S_BIT);
    assign child        = bit_in ? cur_right : cur_left;
    assign unused_rdata = ^mem_rdata[63:18];

    always_comb begin
        state_n = state;
        if (state != S_IDLE && !enabled) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (enabled) state_n = (total_chars == '0) ? S_DONE : S_FETCH;
                S_FETCH: state_n = S_WAIT;
                S_WAIT:  if (mem_ack) state_n = S_BIT;
                S_BIT: begin
                    if (bit_valid) begin
                        if (!child[8])      state_n = S_EMIT;
                        else if (!child[7]) state_n = S_FETCH;
                        else                state_n = S_ERR;
                    end
                end
                // char_count already holds the post-increment value here
                S_EMIT:  state_n = (char_count == total_q) ? S_DONE : S_BIT;
                S_DONE:  state_n = S_DONE;
                S_ERR:   state_n = S_ERR;
                default: state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            char_out   <= '0;
            char_valid <= 1'b0;
            char_count <= '0;
            bit_count  <= '0;
            err        <= 1'b0;
            fin_state  <= 1'b0;
            cur_left   <= '0;
            cur_right  <= '0;
            root_left  <= '0;
            root_right <= '0;
            root_flag  <= 1'b0;
            total_q    <= '0;
        end else begin
            state      <= state_n;
            mem_rd     <= (state_n == S_FETCH);
            char_valid <= (state_n == S_EMIT);
            fin_state  <= (state_n == S_DONE) || (state_n == S_ERR);
            err        <= (state_n == S_ERR);

            if (enabled) begin
                case (state)
                    S_IDLE: begin
                        total_q    <= total_chars;
                        char_count <= '0;
                        bit_count  <= '0;
                        root_flag  <= 1'b1;
                        mem_addr   <= root_index;
                    end
                    S_WAIT: begin
                        if (mem_ack) begin
                            cur_left  <= mem_rdata[17:9];
                            cur_right <= mem_rdata[8:0];
                            if (root_flag) begin
                                root_left  <= mem_rdata[17:9];
                                root_right <= mem_rdata[8:0];
                            end
                        end
                    end
                    S_BIT: begin
                        if (bit_valid) begin
                            bit_count <= bit_count + 1'b1;
                            if (!child[8]) begin
                                char_out   <= child[7:0];
                                char_count <= char_count + 1'b1;
                            end else if (!child[7]) begin
                                mem_addr  <= child[6:0];
                                root_flag <= 1'b0;
                            end
                        end
                    end
                    S_EMIT: begin
                        cur_left  <= root_left;
                        cur_right <= root_right;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_t05_huffman_decoder.sv
// Directed bench for t05_huffman_decoder: table-driven decode cases plus
// hand-written latency, bit-stall and abort sequences against a node-memory model.
module tb_t05_huffman_decoder;

    logic        clk;
    logic        rst;
    logic [3:0]  en_state;
    logic [6:0]  root_index;
    logic [31:0] total_chars;
    logic        bit_in;
    logic        bit_valid;
    logic        bit_ready;
    logic        mem_rd;
    logic [6:0]  mem_addr;
    logic [63:0] mem_rdata;
    logic        mem_ack;
    logic [7:0]  char_out;
    logic        char_valid;
    logic [31:0] char_count;
    logic [31:0] bit_count;
    logic        err;
    logic        fin_state;

    t05_huffman_decoder #(.DECODE_STATE(4'd8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .en_state(en_state), .root_index(root_index),
        .total_chars(total_chars), .bit_in(bit_in), .bit_valid(bit_valid),
        .bit_ready(bit_ready), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .char_out(char_out),
        .char_valid(char_valid), .char_count(char_count), .bit_count(bit_count),
        .err(err), .fin_state(fin_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // node memory model: one outstanding read, ack after lat cycles
    logic [63:0] mem [0:127];
    int          lat;
    int          rd_n;
    logic [6:0]  rd_log [0:7];
    logic        pend;
    int          cnt;
    logic [6:0]  paddr;

    initial begin
        mem_ack   = 1'b0;
        mem_rdata = '1;
        pend      = 1'b0;
        cnt       = 0;
        paddr     = '0;
        rd_n      = 0;
        lat       = 1;
        for (int i = 0; i < 128; i++) mem[i] = '0;
    end

    always @(negedge clk) begin
        mem_ack   = 1'b0;
        mem_rdata = '1;
        if (pend) begin
            cnt = cnt - 1;
            if (cnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[paddr];
                pend      = 1'b0;
            end
        end
        if (mem_rd === 1'b1) begin
            pend  = 1'b1;
            cnt   = lat;
            paddr = mem_addr;
            if (rd_n < 8) rd_log[rd_n] = mem_addr;
            rd_n = rd_n + 1;
        end
    end

    int checks;
    int failures;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [17:0] n0;
        logic [17:0] n1;
        logic [6:0]  root;
        logic [31:0] total;
        logic [7:0]  bits;
        int          nbits;
        int          lat;
        logic [31:0] chars;
        int          nch;
        int          nrd;
        logic [20:0] addrs;
        logic        exp_err;
    } vec_t;

    vec_t tv [6];

    task automatic run_case(input int i);
        vec_t       v;
        int         idx, nch, fin_t, last_cv;
        logic [7:0] got [4];
        logic       seen_fin, overlap, late;
        v = tv[i];
        mem[0] = {46'd0, v.n0};
        mem[1] = {46'd0, v.n1};
        lat  = v.lat;
        rd_n = 0;
        @(negedge clk);
        en_state    = 4'd8;
        root_index  = v.root;
        total_chars = v.total;
        bit_valid   = 1'b0;
        bit_in      = 1'b0;
        idx = 0; nch = 0; fin_t = -1; last_cv = -1;
        overlap = 1'b0; seen_fin = 1'b0;
        for (int t = 1; t <= 300 && !seen_fin; t++) begin
            @(negedge clk);
            if (char_valid) begin
                if (bit_ready) overlap = 1'b1;
                if (nch < 4) got[nch] = char_out;
                nch++;
                last_cv = t;
            end
            if (fin_state) begin
                seen_fin = 1'b1;
                fin_t    = t;
            end else if (idx < v.nbits) begin
                bit_valid = 1'b1;
                bit_in    = v.bits[idx];
                if (bit_ready) idx++;
            end else begin
                bit_valid = 1'b0;
            end
        end
        bit_valid = 1'b0;
        chk($sformatf("c%0d_fin_seen", i), 64'(seen_fin), 64'd1);
        chk($sformatf("c%0d_nchars", i), 64'(nch), 64'(v.nch));
        for (int k = 0; k < v.nch && k < 4; k++)
            chk($sformatf("c%0d_char%0d", i, k), 64'(got[k]), 64'(v.chars[8*k +: 8]));
        chk($sformatf("c%0d_nreads", i), 64'(rd_n), 64'(v.nrd));
        for (int k = 0; k < v.nrd && k < 3; k++)
            chk($sformatf("c%0d_raddr%0d", i, k), 64'(rd_log[k]), 64'(v.addrs[7*k +: 7]));
        chk($sformatf("c%0d_err", i), 64'(err), 64'(v.exp_err));
        chk($sformatf("c%0d_bit_count", i), 64'(bit_count), 64'(v.nbits));
        chk($sformatf("c%0d_char_count", i), 64'(char_count), 64'(v.nch));
        chk($sformatf("c%0d_cv_ready_overlap", i), 64'(overlap), 64'd0);
        if (v.total == 0)
            chk($sformatf("c%0d_fin_time", i), 64'(fin_t), 64'd1);
        else if (!v.exp_err)
            chk($sformatf("c%0d_fin_time", i), 64'(fin_t), 64'(last_cv + 1));
        late = 1'b0;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            if (bit_ready || char_valid || mem_rd || !fin_state) late = 1'b1;
        end
        chk($sformatf("c%0d_quiet_after_fin", i), 64'(late), 64'd0);
        en_state = 4'd0;
        @(negedge clk);
        chk($sformatf("c%0d_abort_clear", i),
            64'({fin_state, err, bit_ready, mem_rd, char_valid}), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        logic [6:0] rdp, brp;
        logic       addr_bad, stall_bad, found;
        checks = 0;
        failures = 0;

        // two-leaf
        tv[0] = '{n0: {9'h041, 9'h042}, n1: 18'd0, root: 7'd0, total: 32'd4, bits: 8'h06,
                  nbits: 4, lat: 1, chars: 32'h41424241, nch: 4, nrd: 1, addrs: 21'd0, exp_err: 1'b0};
        // deep tree, reads 1,0,0
        tv[1] = '{n0: {9'h044, 9'h045}, n1: {9'h043, 9'h100}, root: 7'd1, total: 32'd3, bits: 8'h0D,
                  nbits: 5, lat: 1, chars: 32'h00434544, nch: 3, nrd: 3, addrs: 21'd1, exp_err: 1'b0};
        // slow memory
        tv[2] = '{n0: {9'h041, 9'h042}, n1: 18'd0, root: 7'd0, total: 32'd2, bits: 8'h01,
                  nbits: 2, lat: 5, chars: 32'h00004142, nch: 2, nrd: 1, addrs: 21'd0, exp_err: 1'b0};
        // empty sentinel child
        tv[3] = '{n0: {9'h180, 9'h041}, n1: 18'd0, root: 7'd0, total: 32'd1, bits: 8'h00,
                  nbits: 1, lat: 1, chars: 32'd0, nch: 0, nrd: 1, addrs: 21'd0, exp_err: 1'b1};
        // zero characters requested
        tv[4] = '{n0: {9'h041, 9'h042}, n1: 18'd0, root: 7'd0, total: 32'd0, bits: 8'h00,
                  nbits: 0, lat: 1, chars: 32'd0, nch: 0, nrd: 0, addrs: 21'd0, exp_err: 1'b0};
        // out-of-range internal index
        tv[5] = '{n0: {9'h041, 9'h1C5}, n1: 18'd0, root: 7'd0, total: 32'd2, bits: 8'h01,
                  nbits: 1, lat: 1, chars: 32'd0, nch: 0, nrd: 1, addrs: 21'd0, exp_err: 1'b1};

        rst = 1'b1;
        en_state = 4'd0; root_index = '0; total_chars = '0; bit_in = 1'b0; bit_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_flags", 64'({mem_rd, char_valid, bit_ready, err, fin_state}), 64'd0);
        chk("reset_addr_char", 64'({mem_addr, char_out}), 64'd0);
        chk("reset_counts", 64'({char_count, bit_count}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 6; i++) run_case(i);

        // latency 5: exact mem_rd / bit_ready timing, then a 10-cycle bit stall
        mem[0] = {46'd0, 9'h041, 9'h042};
        lat = 5; rd_n = 0;
        @(negedge clk);
        en_state = 4'd8; root_index = 7'd0; total_chars = 32'd1; bit_valid = 1'b0;
        rdp = '0; brp = '0; addr_bad = 1'b0;
        for (int t = 1; t <= 7; t++) begin
            @(negedge clk);
            rdp[t-1] = mem_rd;
            brp[t-1] = bit_ready;
            if (mem_addr !== 7'd0) addr_bad = 1'b1;
        end
        chk("lat_mem_rd_pattern", 64'(rdp), 64'h01);
        chk("lat_bit_ready_pattern", 64'(brp), 64'h40);
        chk("lat_addr_stable", 64'(addr_bad), 64'd0);
        stall_bad = 1'b0;
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            if (!bit_ready || bit_count !== 32'd0 || char_valid) stall_bad = 1'b1;
        end
        chk("stall_no_change", 64'(stall_bad), 64'd0);
        bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        chk("lat_emit", 64'({char_valid, bit_ready, char_out}), 64'({1'b1, 1'b0, 8'h42}));
        chk("lat_counts", 64'({char_count, bit_count}), {32'd1, 32'd1});
        @(negedge clk);
        chk("lat_fin", 64'({fin_state, char_valid, bit_ready}), 64'b100);
        en_state = 4'd0;
        repeat (3) @(negedge clk);

        // abort mid-walk while a non-root read is outstanding, then restart
        mem[0] = {46'd0, tv[1].n0};
        mem[1] = {46'd0, tv[1].n1};
        lat = 8; rd_n = 0;
        @(negedge clk);
        en_state = 4'd8; root_index = 7'd1; total_chars = 32'd3; bit_valid = 1'b0;
        found = 1'b0;
        for (int t = 0; t < 30 && !found; t++) begin
            @(negedge clk);
            if (bit_ready) found = 1'b1;
        end
        chk("abort_reached_bit", 64'(found), 64'd1);
        bit_valid = 1'b1; bit_in = 1'b1;
        @(negedge clk);
        bit_valid = 1'b0;
        chk("abort_refetch", 64'({mem_rd, mem_addr}), 64'({1'b1, 7'd0}));
        @(negedge clk);
        en_state = 4'd0;
        @(negedge clk);
        chk("abort_clear", 64'({fin_state, err, bit_ready, mem_rd, char_valid}), 64'd0);
        stall_bad = 1'b0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk);
            if (bit_ready || fin_state || mem_rd) stall_bad = 1'b1;
        end
        chk("abort_late_ack_ignored", 64'(stall_bad), 64'd0);
        run_case(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
